// File: rtl/instr_encoder_loader_if.sv
// Handshake bundle between the field source, the encoder/loader and the
// instruction memory write port. The field source and the memory together
// form the master side; the loader is the slave.
interface instr_encoder_loader_if;
    // Decoded-field channel
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    // Instruction-memory write channel
    logic        wr_en;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32 instruction encoder and instruction-memory loader. Field bundles are
// packed into 32-bit words, buffered in a small FIFO and written to
// consecutive word addresses starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH      = 256,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(DEPTH):0] word_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FIFO_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Opcode classes shared with the core's field decoder
    localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
    localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_JUMP    = 7'b1101111;
    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_NOP     = 7'b0000000;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;
    logic             err_q;
    logic [31:0]      mem [FIFO_DEPTH];

    fmt_t        fmt;
    logic [31:0] enc_word;
    logic        imm_bad;
    logic        in_ready;
    logic        session_start, fifo_full, fifo_empty;
    logic        accept, push, pop, last_accept;

    assign session_start = start && (state_q == S_IDLE || state_q == S_DONE);
    assign fifo_full     = (fifo_cnt_q == FIFO_FULL);
    assign fifo_empty    = (fifo_cnt_q == '0);
    assign accept        = bus.in_valid && in_ready;
    assign push          = accept && !imm_bad;
    assign pop           = !fifo_empty && bus.wr_ready;
    assign last_accept   = accept && (bus.in_last || acc_cnt_q == DEPTH_C - CNT_ONE);

    // Select the instruction layout from the opcode class, pack the fields
    // and flag immediates the chosen layout cannot represent
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves a value unassigned, which would infer a latch.
        fmt      = FMT_NONE;
        enc_word = '0;
        imm_bad  = 1'b0;
        case (bus.in_opcode)
            OPCODE_ALU, OPCODE_NOP:       fmt = FMT_R;
            OPCODE_ALU_IMM, OPCODE_LOAD:  fmt = FMT_I;
            OPCODE_STORE:                 fmt = FMT_S;
            OPCODE_BRANCH:                fmt = FMT_B;
            OPCODE_JUMP:                  fmt = FMT_J;
            OPCODE_LUI, OPCODE_AUIPC:     fmt = FMT_U;
            default:                      fmt = FMT_NONE;
        endcase
        case (fmt)
            FMT_R: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               bus.in_rd, bus.in_opcode};
            FMT_I: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                            bus.in_opcode};
                imm_bad  = bus.in_imm[31:12] != {20{bus.in_imm[11]}};
            end
            FMT_S: begin
                enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_imm[4:0], bus.in_opcode};
                imm_bad  = bus.in_imm[31:12] != {20{bus.in_imm[11]}};
            end
            FMT_B: begin
                enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
                imm_bad  = (bus.in_imm[31:13] != {19{bus.in_imm[12]}}) || bus.in_imm[0];
            end
            FMT_U: begin
                enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
                imm_bad  = bus.in_imm[11:0] != '0;
            end
            FMT_J: begin
                enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                            bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
                imm_bad  = (bus.in_imm[31:21] != {11{bus.in_imm[20]}}) || bus.in_imm[0];
            end
            default: imm_bad = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start)       state_d = S_LOAD;
            S_LOAD:         if (last_accept) state_d = S_DRAIN;
            S_DRAIN:        if (fifo_empty)  state_d = S_DONE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // FSM outputs: status flags and the accept window
    always_comb begin
        busy     = (state_q == S_LOAD) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
        in_ready = (state_q == S_LOAD) && !fifo_full && (acc_cnt_q < DEPTH_C);
    end

    // Next values for counters, FIFO pointers and the write address
    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (session_start) begin
            acc_cnt_d  = '0;
            word_cnt_d = '0;
            addr_d     = BASE_ADDR;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (accept) acc_cnt_d = acc_cnt_q + CNT_ONE;
            if (push)   wr_ptr_d  = wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                word_cnt_d = word_cnt_q + CNT_ONE;
                addr_d     = addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + FIFO_ONE;
                2'b01:   fifo_cnt_d = fifo_cnt_q - FIFO_ONE;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // Datapath registers and the one-cycle reject pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_cnt_q  <= '0;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            err_q      <= accept && imm_bad;
        end
    end

    // FIFO storage written at the accepting edge
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only read while
        // the occupancy count says they hold valid data.
        if (push) mem[wr_ptr_q] <= enc_word;
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = !fifo_empty;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = fifo_empty ? '0 : mem[rd_ptr_q];
    assign err          = err_q;
    assign word_count   = word_cnt_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a table of single-bundle sessions
// plus hand-written sequences for throughput, backpressure, rejects, the
// DEPTH limit and mid-session reset.
module tb_instr_encoder_loader;
    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0, reset_n = 1'b0, start0 = 1'b0, start4 = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, wr_ready = 1'b1;
    logic [6:0]  in_opcode = '0, in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_imm = '0;

    logic       busy0, done0, err0, busy4, done4, err4;
    logic [8:0] wc0;
    logic [2:0] wc4;

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [31:0] wq_addr[$], wq_data[$], w4_addr[$], w4_data[$];
    int          wq_cyc[$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = '0, stall_data = '0;
    vec_t        vecs[20];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder_loader_if bus0 ();
    instr_encoder_loader_if bus4 ();

    assign bus0.in_valid = in_valid;   assign bus4.in_valid = in_valid;
    assign bus0.in_last = in_last;     assign bus4.in_last = in_last;
    assign bus0.in_opcode = in_opcode; assign bus4.in_opcode = in_opcode;
    assign bus0.in_rd = in_rd;         assign bus4.in_rd = in_rd;
    assign bus0.in_rs1 = in_rs1;       assign bus4.in_rs1 = in_rs1;
    assign bus0.in_rs2 = in_rs2;       assign bus4.in_rs2 = in_rs2;
    assign bus0.in_funct3 = in_funct3; assign bus4.in_funct3 = in_funct3;
    assign bus0.in_funct7 = in_funct7; assign bus4.in_funct7 = in_funct7;
    assign bus0.in_imm = in_imm;       assign bus4.in_imm = in_imm;
    assign bus0.wr_ready = wr_ready;   assign bus4.wr_ready = wr_ready;

    instr_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(256), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start0), .bus(bus0),
        .busy(busy0), .done(done0), .err(err0), .word_count(wc0)
    );

    instr_encoder_loader #(.BASE_ADDR(32'h0000_1000), .DEPTH(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .bus(bus4),
        .busy(busy4), .done(done4), .err(err4), .word_count(wc4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] w, input logic e);
        vec_t v;
        v.name = name; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_word = w; v.exp_err = e;
        return v;
    endfunction

    // ADDI x1,x0,(k+1): imm lands in [31:20], rd=1 in [11:7], opcode 0x13
    function automatic vec_t addi_k(input int k);
        return mk("addi_k", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1),
                  (32'(k + 1) << 20) | 32'h0000_0093, 1'b0);
    endfunction

    task automatic drive(input vec_t v);
        in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input string name);
        for (int i = 0; i < 50 && !done0; i++) step();
        check_b({name, " done"}, done0, 1'b1);
    endtask

    task automatic clear_q();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        w4_addr.delete(); w4_data.delete();
    endtask

    // Write capture and hold-while-stalled checking, away from the active edge
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_b("stall wr_en held", bus0.wr_en, 1'b1);
                check("stall wr_addr held", bus0.wr_addr, stall_addr);
                check("stall wr_data held", bus0.wr_data, stall_data);
            end
            if (bus0.wr_en && bus0.wr_ready) begin
                wq_addr.push_back(bus0.wr_addr);
                wq_data.push_back(bus0.wr_data);
                wq_cyc.push_back(cyc);
            end
            stall_prev = bus0.wr_en && !bus0.wr_ready;
            stall_addr = bus0.wr_addr;
            stall_data = bus0.wr_data;
            if (bus4.wr_en && bus4.wr_ready) begin
                w4_addr.push_back(bus4.wr_addr);
                w4_data.push_back(bus4.wr_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // One bundle with in_last=1 in a fresh session
    task automatic run_one(input vec_t v);
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        check_b({v.name, " in_ready"}, bus0.in_ready, 1'b1);
        drive(v); in_valid = 1'b1; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check_b({v.name, " err"}, err0, v.exp_err);
        check_b({v.name, " wr_en"}, bus0.wr_en, !v.exp_err);
        if (!v.exp_err) begin
            check({v.name, " wr_data"}, bus0.wr_data, v.exp_word);
            check({v.name, " wr_addr"}, bus0.wr_addr, 32'h0);
        end
        step();
        check_b({v.name, " err pulse end"}, err0, 1'b0);
        wait_done0(v.name);
        check({v.name, " word_count"}, 32'(wc0), v.exp_err ? 32'd0 : 32'd1);
        check({v.name, " writes"}, 32'(wq_addr.size()), v.exp_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        int idx;
        logic rdy;

        vecs[0]  = mk("addi x1,x0,5",  7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h0050_0093, 1'b0);
        vecs[1]  = mk("sw x2,8(x1)",   7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020_A423, 1'b0);
        vecs[2]  = mk("beq -4",        7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        vecs[3]  = mk("jal x1,8",      7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        32'h0080_00EF, 1'b0);
        vecs[4]  = mk("lui x5",        7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        vecs[5]  = mk("mul x3,x1,x2",  7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'd1, 32'd0,        32'h0220_81B3, 1'b0);
        vecs[6]  = mk("lw x5,-8(x2)",  7'h03, 5'd5,  5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFF81_2283, 1'b0);
        vecs[7]  = mk("auipc x10",     7'h17, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'hFFFF_F517, 1'b0);
        vecs[8]  = mk("nop raw",       7'h00, 5'd1,  5'd2, 5'd3, 3'd4, 7'd5, 32'd0,        32'h0A31_4080, 1'b0);
        vecs[9]  = mk("addi -2048",    7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        vecs[10] = mk("addi 2047",     7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,     32'h7FF0_0093, 1'b0);
        vecs[11] = mk("beq 4094",      7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,     32'h7E00_0FE3, 1'b0);
        vecs[12] = mk("jal min",       7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
        vecs[13] = mk("addi 4096",     7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,     32'h0,         1'b1);
        vecs[14] = mk("beq 3",         7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h0,         1'b1);
        vecs[15] = mk("bad opcode",    7'h7F, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        32'h0,         1'b1);
        vecs[16] = mk("lui low bits",  7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0,         1'b1);
        vecs[17] = mk("sw 2048",       7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 7'd0, 32'd2048,     32'h0,         1'b1);
        vecs[18] = mk("jal 2^20",      7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0,         1'b1);
        vecs[19] = mk("beq 4096",      7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,     32'h0,         1'b1);

        // Reset state
        #12;
        check_b("reset in_ready", bus0.in_ready, 1'b0);
        check_b("reset wr_en", bus0.wr_en, 1'b0);
        check("reset wr_addr", bus0.wr_addr, 32'h0);
        check("reset wr_data", bus0.wr_data, 32'h0);
        check_b("reset busy", busy0, 1'b0);
        check_b("reset done", done0, 1'b0);
        check_b("reset err", err0, 1'b0);
        check("reset word_count", 32'(wc0), 32'd0);
        check("reset wr_addr base4", bus4.wr_addr, 32'h0000_1000);
        @(negedge clk) reset_n = 1'b1;
        step();
        in_valid = 1'b1; drive(vecs[0]);
        step();
        check_b("idle ignores in_valid", busy0, 1'b0);
        check("idle no accept", 32'(wq_addr.size()), 32'd0);
        in_valid = 1'b0;

        // Table of single-bundle sessions
        for (int i = 0; i < 20; i++) run_one(vecs[i]);

        // Back-to-back stream, one write per cycle at consecutive addresses
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(vecs[k]); in_valid = 1'b1; in_last = (k == 5);
            check_b("b2b in_ready", bus0.in_ready, 1'b1);
            if (k == 2) check_b("b2b first-write latency", bus0.wr_en, 1'b1);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_done0("b2b");
        check("b2b write count", 32'(wq_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < wq_addr.size()) begin
                check("b2b wr_addr", wq_addr[i], 32'(4 * i));
                check("b2b wr_data", wq_data[i], vecs[i + 1].exp_word);
                check("b2b cycle spacing", 32'(wq_cyc[i] - wq_cyc[0]), 32'(i));
            end
        end
        check("b2b word_count", 32'(wc0), 32'd5);

        // Backpressure: FIFO fills, outputs hold, then drains in order
        clear_q();
        wr_ready = 1'b0;
        start0 = 1'b1; step(); start0 = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            drive(addi_k(idx)); in_valid = 1'b1; in_last = (idx == 5);
            rdy = bus0.in_ready;
            step();
            if (rdy) idx++;
        end
        check("stall accepted count", 32'(idx), 32'd4);
        check_b("stall in_ready low", bus0.in_ready, 1'b0);
        check("stall head data", bus0.wr_data, addi_k(0).exp_word);
        check("stall no writes", 32'(wq_addr.size()), 32'd0);
        wr_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            drive(addi_k(idx)); in_valid = 1'b1; in_last = (idx == 5);
            rdy = bus0.in_ready;
            step();
            if (rdy) idx++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_done0("stall");
        check("stall write count", 32'(wq_addr.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wq_addr.size()) begin
                check("stall order addr", wq_addr[i], 32'(4 * i));
                check("stall order data", wq_data[i], addi_k(i).exp_word);
            end
        end

        // Rejects consume no address; the next good bundle lands at +0
        clear_q();
        start0 = 1'b1; step(); start0 = 1'b0;
        drive(vecs[13]); in_valid = 1'b1; in_last = 1'b0;
        step();
        check_b("reject1 err", err0, 1'b1);
        drive(vecs[14]);
        step();
        check_b("reject2 err", err0, 1'b1);
        check_b("reject2 no wr_en", bus0.wr_en, 1'b0);
        drive(vecs[0]); in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check_b("reject good err", err0, 1'b0);
        check("reject good addr", bus0.wr_addr, 32'h0);
        wait_done0("reject");
        check("reject write count", 32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() > 0) check("reject good data", wq_data[0], 32'h0050_0093);
        check("reject word_count", 32'(wc0), 32'd1);

        // DEPTH=4 instance: six bundles offered without in_last
        clear_q();
        start4 = 1'b1; step(); start4 = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            drive(addi_k(idx % 6)); in_valid = (idx < 6); in_last = 1'b0;
            rdy = bus4.in_ready && in_valid;
            step();
            if (rdy) idx++;
        end
        in_valid = 1'b0;
        check("depth accepted count", 32'(idx), 32'd4);
        check_b("depth in_ready low", bus4.in_ready, 1'b0);
        for (int i = 0; i < 50 && !done4; i++) step();
        check_b("depth done", done4, 1'b1);
        check("depth word_count", 32'(wc4), 32'd4);
        check("depth write count", 32'(w4_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < w4_addr.size()) begin
                check("depth wr_addr", w4_addr[i], 32'h0000_1000 + 32'(4 * i));
                check("depth wr_data", w4_data[i], addi_k(i).exp_word);
            end
        end
        start4 = 1'b1; step(); start4 = 1'b0;
        check("restart wr_addr", bus4.wr_addr, 32'h0000_1000);
        check("restart word_count", 32'(wc4), 32'd0);
        check_b("restart busy", busy4, 1'b1);

        // Mid-session reset with two words buffered
        clear_q();
        wr_ready = 1'b1;
        start0 = 1'b1; step(); start0 = 1'b0;
        drive(addi_k(0)); in_valid = 1'b1; in_last = 1'b0;
        step();
        drive(addi_k(1));
        step();
        wr_ready = 1'b0; drive(addi_k(2));
        step();
        in_valid = 1'b0;
        check("pre-reset word_count", 32'(wc0), 32'd1);
        check("pre-reset wr_addr", bus0.wr_addr, 32'h4);
        #2 reset_n = 1'b0;
        #1;
        check_b("async reset wr_en", bus0.wr_en, 1'b0);
        check("async reset wr_addr", bus0.wr_addr, 32'h0);
        check("async reset wr_data", bus0.wr_data, 32'h0);
        check_b("async reset busy", busy0, 1'b0);
        check_b("async reset in_ready", bus0.in_ready, 1'b0);
        check("async reset word_count", 32'(wc0), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; wr_ready = 1'b1;
        clear_q();
        step();
        start0 = 1'b1; step(); start0 = 1'b0;
        drive(vecs[3]); in_valid = 1'b1; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        wait_done0("post-reset");
        check("post-reset write count", 32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() > 0) begin
            check("post-reset wr_addr", wq_addr[0], 32'h0);
            check("post-reset wr_data", wq_data[0], 32'h0080_00EF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential RISC-V instruction encoder and instruction-memory loader. It accepts decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs them into 32-bit RV32 words using the R/I/S/B/U/J layouts. It buffers the words in a small FIFO and writes them sequentially into instruction memory through a backpressured write port. It sits between the test/boot field source and the instruction memory, and is the inverse of the core's field decoder.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first written word
- DEPTH, 256, maximum words written per load session
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  pulse; begins a session (ignored unless IDLE or DONE)
- in_valid  input  1  field bundle valid
- in_ready  output  1  bundle accepted when in_valid && in_ready
- in_last  input  1  marks the final bundle of the session
- in_opcode  input  7  / in_rd, in_rs1, in_rs2  input  5 each / in_funct3  input  3 / in_funct7  input  7 / in_imm  input  32 (sign-extended byte offset or U value)
- wr_en  output  1  write request
- wr_ready  input  1  memory accepts the write when wr_en && wr_ready
- wr_addr  output  32  byte address
- wr_data  output  32  encoded instruction
- busy  output  1  state is LOAD or DRAIN
- done  output  1  state is DONE
- err  output  1  one-cycle pulse: the accepted bundle was rejected
- word_count  output  $clog2(DEPTH)+1  words written this session

## Operation
- FSM has four states: IDLE, LOAD, DRAIN and DONE. Reset puts it in IDLE.
- IDLE/DONE + start → LOAD. The session start clears word_count, the address counter (set to BASE_ADDR) and the FIFO.
- LOAD: in_ready = FIFO not full && (accepted count < DEPTH).
- LOAD → DRAIN on acceptance of a bundle with in_last=1. The same transition happens on the acceptance that brings the accepted count to DEPTH.
- DRAIN: in_ready=0. DRAIN → DONE when the FIFO is empty and no write is outstanding.
- Format is selected by opcode class using the shared defines:
  - `OPCODE_ALU` → R.
  - `OPCODE_ALU_IMM` and `OPCODE_LOAD` → I.
  - `OPCODE_STORE` → S.
  - `OPCODE_BRANCH` → B.
  - `OPCODE_JUMP` → J.
  - `OPCODE_LUI` and `OPCODE_AUIPC` → U.
  - `OPCODE_NOP` → R with the fields passed raw.
- Field packing, with opcode always in [6:0]:
  - R: funct7, rs2, rs1, funct3, rd.
  - I: imm[11:0], rs1, funct3, rd.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0].
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11].
  - U: imm[31:12], rd.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd.
- A bundle is rejected (err=1, nothing enqueued, no address consumed; it still counts toward in_last/DEPTH handling) when any of these holds:
  - The opcode matches no class.
  - I/S: imm is not a sign-extension of imm[11:0].
  - B: imm is not a sign-extension of imm[12:0], or imm[0]≠0.
  - J: imm is not a sign-extension of imm[20:0], or imm[0]≠0.
  - U: imm[11:0]≠0.
- Encoding is combinational on the input fields. The encoded word is enqueued at the accepting edge.
- Write port: wr_en = FIFO not empty. wr_data is the FIFO head. wr_addr = BASE_ADDR + 4·word_count.
- On each completed write, the FIFO pops, word_count increments and the address advances by 4. Addresses wrap modulo 2^32.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, word_count=0.
- Latency: a bundle accepted at edge N gives wr_en=1 in cycle N+1, provided the FIFO was empty.
- Sustained throughput is 1 word/cycle with wr_ready held high.
- wr_en, wr_addr and wr_data are held stable until the write completes. They never change while wr_en=1 && wr_ready=0.
- Simultaneous enqueue and dequeue on a full FIFO is allowed only as dequeue-first. in_ready is computed from pre-edge occupancy, so an accept into a full FIFO never occurs.
- err pulses in cycle N+1 for a rejected bundle accepted at edge N.
- start while busy is ignored. in_valid in IDLE/DONE is not accepted.
- A reset_n assertion mid-session aborts immediately. All outputs take their reset values asynchronously, and buffered words are discarded.

## Test plan
- ADDI x1,x0,5 (opcode 0010011, rd=1, imm=5) with in_last=1 → one write, wr_data=0x00500093, wr_addr=BASE_ADDR, then done=1 and word_count=1.
- Back-to-back SW x2,8(x1), BEQ x0,x0,-4, JAL x1,8, LUI x5 imm=0x12345000, MUL x3,x1,x2 with wr_ready=1 → writes 0x0020A423, 0xFE000EE3, 0x008000EF, 0x123452B7, 0x022081B3 at consecutive addresses +0, +4, +8, +12, +16, one per cycle.
- wr_ready=0 for 10 cycles with continuous in_valid → exactly FIFO_DEPTH bundles accepted, then in_ready=0. wr_* stay stable. On release, all words are written in order with no loss or duplication.
- ADDI with imm=4096, and BEQ with imm=3 → err pulses, no write, and the next valid bundle is written at the unconsumed address.
- DEPTH=4 with 6 bundles offered and no in_last → 4 accepted, then DRAIN→DONE with word_count=4. A new start resets wr_addr to BASE_ADDR.
- reset_n low mid-stream with 2 words buffered → all outputs reset immediately. After release and start, writes begin at BASE_ADDR.
